// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   UART_OVERSAMPLE - sample ticks per bit (16)
//   UART_DATA_BITS  - data bits per frame (8)
//   rx_state_t      - deserializer FSM states
//   hs_state_t      - register-file handshake FSM states
//   uart_div()      - clocks per sample tick, truncated
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WRITE,
        H_PEND
    } hs_state_t;

    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rx pin synchronizer, oversampling tick generator and 8N1
// deserializer.
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   rx_i         raw serial input (idle high)
//   rx_byte_o    assembled byte, valid while byte_valid_o is high
//   byte_valid_o one-cycle pulse: a frame with a good stop bit completed
//   frame_err_o  one-cycle pulse: stop bit sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          SC_W  = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

    logic             rx_p0;
    logic             rx_p1;
    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [SC_W-1:0]  smp_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    rx_state_t        state;

    // Sync stage: two flops, preset to the idle level so reset never looks
    // like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    // Tick stage: held at zero while idle so the first tick of a frame is
    // aligned to the detected falling edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_cnt <= '0;
        end else if (state == R_IDLE || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (state != R_IDLE) && (div_cnt == DIV_LAST);

    // Frame stage
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= R_IDLE;
            smp_cnt      <= '0;
            bit_cnt      <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                R_IDLE: begin
                    smp_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_p1) state <= R_START;
                end
                R_START: if (tick) begin
                    // Mid start bit: re-check to reject glitches, then
                    // restart the count so data bits are sampled mid-bit.
                    if (smp_cnt == SC_MID) begin
                        smp_cnt <= '0;
                        state   <= rx_p1 ? R_IDLE : R_DATA;
                    end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                R_DATA: if (tick) begin
                    smp_cnt <= smp_cnt + 1'b1;
                    if (smp_cnt == SC_LAST) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= R_STOP;
                    end
                end
                R_STOP: if (tick) begin
                    smp_cnt <= smp_cnt + 1'b1;
                    if (smp_cnt == SC_LAST) begin
                        if (rx_p1) begin
                            state        <= R_DONE;
                            byte_valid_o <= 1'b1;
                        end else begin
                            state       <= R_IDLE;
                            frame_err_o <= 1'b1;
                        end
                    end
                end
                R_DONE:  state <= R_IDLE;
                default: state <= R_IDLE;
            endcase
        end
    end

    // Data stage: LSB arrives first, so shift in from the top.
    always_ff @(posedge clk_i) begin
        if (state == R_DATA && tick && smp_cnt == SC_LAST) begin
            shreg <= {rx_p1, shreg[7:1]};
        end
    end

    assign rx_byte_o = shreg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Deserializes frames via
// uart_rx_core and hands each good byte to the register file.
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   rx_i         serial input (idle high)
//   data_ctrl_i  control-register new-data bit read back
//   rx_data_o    last accepted byte (data-register write data)
//   we_data_o    data-register write strobe
//   data_ctrl_o  value written to the new-data bit
//   we_ctrl_o    control-register write strobe
//   frame_err_o  one-cycle pulse on a low stop bit
//   overrun_o    one-cycle pulse when a byte is dropped as still pending
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       data_ctrl_i,
    output logic [7:0] rx_data_o,
    output logic       we_data_o,
    output logic       data_ctrl_o,
    output logic       we_ctrl_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    logic [7:0] core_byte;
    logic       byte_valid;
    hs_state_t  hs_state;

    uart_rx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_core (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .rx_byte_o   (core_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (frame_err_o)
    );

    // Handshake stage
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hs_state    <= H_IDLE;
            rx_data_o   <= 8'h00;
            we_data_o   <= 1'b0;
            data_ctrl_o <= 1'b0;
            we_ctrl_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            we_data_o   <= 1'b0;
            data_ctrl_o <= 1'b0;
            we_ctrl_o   <= 1'b0;
            // Any byte arriving while the last one is unread is dropped.
            overrun_o   <= byte_valid && (hs_state != H_IDLE);
            case (hs_state)
                H_IDLE: if (byte_valid) begin
                    rx_data_o <= core_byte;
                    hs_state  <= H_WRITE;
                end
                H_WRITE: begin
                    we_data_o   <= 1'b1;
                    data_ctrl_o <= 1'b1;
                    we_ctrl_o   <= 1'b1;
                    hs_state    <= H_PEND;
                end
                H_PEND: begin
                    // While the write strobe is out, the read-back bit has
                    // not yet picked up our own write; ignore it that cycle.
                    if (!data_ctrl_i && !we_ctrl_o) hs_state <= H_IDLE;
                end
                default: hs_state <= H_IDLE;
            endcase
        end
    end

endmodule
